// File: rtl/aes_pkg.sv
// Shared AES constants and pure transform helpers for the
// iterative inverse cipher datapath.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } state_t;

  // Byte k sits at row k%4, column k/4, MSB first.
  function automatic int byte_off(input int r, input int c);
    return 127 - 8 * (4 * c + r);
  endfunction

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [3:0] k
  );
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(a);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return (k[0] ? a  : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^
           (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [127:0] inv_shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[byte_off(r, c) -: 8] =
          s[byte_off(r, (c - r + 4) % 4) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(
    input logic [127:0] s
  );
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[byte_off(0, c) -: 8];
      a1 = s[byte_off(1, c) -: 8];
      a2 = s[byte_off(2, c) -: 8];
      a3 = s[byte_off(3, c) -: 8];
      o[byte_off(0, c) -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^
                               gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
      o[byte_off(1, c) -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^
                               gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
      o[byte_off(2, c) -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^
                               gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
      o[byte_off(3, c) -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^
                               gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box lookup, one byte wide.
// Table entry 0 is the most significant byte of TBL.
module aes_inv_sbox (
  input  logic [7:0] x,
  output logic [7:0] s
);

  localparam logic [2047:0] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Entry x starts at bit 2047-8x, i.e. {~x, 3'b111}.
  assign s = TBL[{~x, 3'b111} -: 8];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock,
// round keys fetched from an external expanded-key store.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iValid,
  output logic                 oReady,
  input  logic [AES_BLK_W-1:0] iData,
  output logic [3:0]           oKeyIdx,
  input  logic [KEY_W-1:0]     iRoundKey,
  output logic                 oValid,
  input  logic                 iReady,
  output logic [AES_BLK_W-1:0] oData
);

  localparam logic [3:0] LAST = 4'(NR);

  state_t               state;
  logic [3:0]           rnd;
  logic [AES_BLK_W-1:0] st_q;
  logic [AES_BLK_W-1:0] sr;
  logic [AES_BLK_W-1:0] sb;
  logic [AES_BLK_W-1:0] fin;
  logic [AES_BLK_W-1:0] mid;

  assign sr = inv_shift_rows(st_q);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .x (sr[8*i +: 8]),
      .s (sb[8*i +: 8])
    );
  end

  // Key addition precedes InvMixColumns in this round ordering.
  assign fin = sb ^ iRoundKey;
  assign mid = inv_mix_columns(fin);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state   <= IDLE;
      rnd     <= '0;
      st_q    <= '0;
      oKeyIdx <= LAST;
      oReady  <= 1'b1;
      oValid  <= 1'b0;
      oData   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (iValid) begin
            st_q    <= iData ^ iRoundKey;
            rnd     <= LAST - 4'd1;
            oKeyIdx <= LAST - 4'd1;
            oReady  <= 1'b0;
            state   <= ROUND;
          end
        end
        ROUND: begin
          st_q    <= mid;
          rnd     <= rnd - 4'd1;
          oKeyIdx <= rnd - 4'd1;
          if (rnd == 4'd1)
            state <= FINAL;
        end
        FINAL: begin
          oData   <= fin;
          oValid  <= 1'b1;
          oKeyIdx <= LAST;
          state   <= DONE;
        end
        DONE: begin
          if (iReady) begin
            oValid <= 1'b0;
            oReady <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for the iterative AES-128 inverse cipher.
// The reference S-box is derived from GF(2^8) arithmetic.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iValid;
  logic         oReady;
  logic [127:0] iData;
  logic [3:0]   oKeyIdx;
  logic [127:0] iRoundKey;
  logic         oValid;
  logic         iReady;
  logic [127:0] oData;

  always #5 clk = ~clk;

  logic [127:0] rk [0:15];
  logic [127:0] mk [0:10];
  logic [7:0]   sbox [0:255];

  assign iRoundKey = rk[oKeyIdx];

  aes_inv_cipher_iter #(.NR(10), .KEY_W(128)) dut (
    .iClk      (clk),
    .iRst_n    (rst_n),
    .iValid    (iValid),
    .oReady    (oReady),
    .iData     (iData),
    .oKeyIdx   (oKeyIdx),
    .iRoundKey (iRoundKey),
    .oValid    (oValid),
    .iReady    (iReady),
    .oData     (oData)
  );

  typedef struct {
    logic [127:0] d;
    int           c0;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_v = 1'b0;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] v, input int n);
    logic [7:0] r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rol(inv, 1) ^ rol(inv, 2) ^
                rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] gb(input logic [127:0] s,
                                    input int r, input int c);
    return s[127 - 8 * (4 * c + r) -: 8];
  endfunction

  function automatic logic [127:0] sub_b(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox[s[8*k +: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_r(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8 * (4 * c + r) -: 8] = gb(s, r, (c + r) % 4);
    return o;
  endfunction

  function automatic logic [127:0] mix_c(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [0:3];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = gb(s, r, c);
      for (int r = 0; r < 4; r++)
        o[127 - 8 * (4 * c + r) -: 8] =
          gmul(a[r], 8'h02) ^ gmul(a[(r + 1) % 4], 8'h03) ^
          a[(r + 2) % 4] ^ a[(r + 3) % 4];
    end
    return o;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [127:0] s = pt ^ mk[0];
    for (int r = 1; r < 10; r++) s = mix_c(shift_r(sub_b(s))) ^ mk[r];
    return shift_r(sub_b(s)) ^ mk[10];
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [127:0] key, input logic [127:0] ct,
                      input logic [127:0] pt);
    int n = 0;
    @(negedge clk);
    while (!oReady && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!oReady) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: oReady got 0 want 1");
      return;
    end
    expand(key);
    for (int i = 0; i < 11; i++) rk[i] = mk[i];
    iData  = ct;
    iValid = 1'b1;
    q.push_back('{d: pt, c0: cyc});
    @(posedge clk);
    #1 iValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: pending %0d want 0", q.size());
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && oValid) begin
      if (!prev_v) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got %h want none", oData);
        end else begin
          chk("latency", 128'(cyc - q[0].c0), 128'd11);
        end
      end
      if (iReady && q.size() != 0) begin
        chk("plaintext", oData, q[0].d);
        void'(q.pop_front());
      end
    end
    prev_v <= rst_n && oValid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt2, ct2;
    logic [127:0] key, pt;
    int           c_a, n;

    rst_n  = 1'b0;
    iValid = 1'b0;
    iReady = 1'b1;
    iData  = '0;
    for (int i = 0; i < 16; i++) rk[i] = '0;
    init_sbox();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_oValid", 128'(oValid), 128'd0);
    chk("rst_oReady", 128'(oReady), 128'd1);
    chk("rst_oData", oData, 128'd0);
    chk("rst_oKeyIdx", 128'(oKeyIdx), 128'd10);
    rst_n = 1'b1;

    // FIPS-197 C.1 with key index sequence
    send(K_C1, CT_C1, PT_C1);
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      chk($sformatf("keyidx_c%0d", j), 128'(oKeyIdx),
          128'((j == 10) ? 0 : ((j == 11) ? 10 : 10 - j)));
    end
    drain();

    // all-zero key with downstream stall
    @(posedge clk);
    #1 iReady = 1'b0;
    send('0, CT_Z, '0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!oValid && n < 50);
    chk("stall_seen", 128'(oValid), 128'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", 128'(oValid), 128'd1);
      chk("stall_data", oData, 128'd0);
      chk("stall_ready", 128'(oReady), 128'd0);
    end
    @(posedge clk);
    #1 iReady = 1'b1;
    drain();

    // back-to-back with iValid held high
    pt2 = 128'hffeeddccbbaa99887766554433221100;
    expand(K_C1);
    ct2 = enc(pt2);
    @(negedge clk);
    for (int i = 0; i < 11; i++) rk[i] = mk[i];
    iData  = CT_C1;
    iValid = 1'b1;
    c_a    = cyc;
    q.push_back('{d: PT_C1, c0: cyc});
    @(posedge clk);
    #1 iData = ct2;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!oReady && n < 50);
    chk("b2b_gap", 128'(cyc - c_a), 128'd12);
    q.push_back('{d: pt2, c0: cyc});
    @(posedge clk);
    #1 iValid = 1'b0;
    drain();

    // iValid pulse during ROUND is ignored
    send(K_C1, CT_C1, PT_C1);
    repeat (3) @(posedge clk);
    #1;
    iValid = 1'b1;
    iData  = ~CT_C1;
    @(negedge clk);
    chk("busy_ready", 128'(oReady), 128'd0);
    @(posedge clk);
    #1 iValid = 1'b0;
    drain();

    // reset mid-operation
    send(K_C1, CT_C1, PT_C1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    #1;
    chk("abort_oValid", 128'(oValid), 128'd0);
    chk("abort_oReady", 128'(oReady), 128'd1);
    chk("abort_oData", oData, 128'd0);
    chk("abort_oKeyIdx", 128'(oKeyIdx), 128'd10);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(K_C1, CT_C1, PT_C1);
    drain();

    // encrypt/decrypt round trip
    for (int b = 0; b < 1000; b++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand(key);
      send(key, enc(pt), pt);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative AES-128 inverse cipher (decryption datapath). It is the decrypt-direction counterpart of the encryption round logic.
- Processes one 128-bit ciphertext block at a time and performs one inverse round per clock.
- Round keys come from an external, already-expanded key store, indexed by this block.
- Sits between the ciphertext input stream and the plaintext output stream. Both sides use valid/ready handshakes.

Parameters:
- NR, 10, number of AES rounds. Fixed for AES-128; other values are not supported.
- KEY_W, 128, round-key width in bits.

Ports:
- iClk  input  1  system clock, rising edge.
- iRst_n  input  1  reset, asynchronous, active-low.
- iValid  input  1  ciphertext block valid.
- oReady  output  1  core can accept a block (IDLE state only).
- iData  input  128  ciphertext. Byte 0 is in iData[127:120]; column-major state mapping, byte k = row k%4, column k/4.
- oKeyIdx  output  4  round-key index requested, 0..10.
- iRoundKey  input  128  round key for oKeyIdx. Combinational: valid in the same cycle, same byte mapping as iData.
- oValid  output  1  plaintext valid.
- iReady  input  1  downstream accepts plaintext.
- oData  output  128  plaintext, same byte mapping as iData.

Behaviour:
- Reset (asynchronous, iRst_n=0):
  - state = IDLE, round counter = 0, state register = 0.
  - oValid=0, oData=0, oReady=1, oKeyIdx=10.
- State machine: IDLE -> ROUND -> FINAL -> DONE -> IDLE.
- IDLE:
  - oReady=1 and oKeyIdx=10.
  - On iValid=1: state_reg <= iData ^ iRoundKey (rk10), rnd <= 9, go to ROUND.
- ROUND (rnd = 9 down to 1):
  - oKeyIdx = rnd.
  - state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ iRoundKey).
  - rnd decrements each cycle. Leave for FINAL after rnd=1 is processed.
- FINAL:
  - oKeyIdx = 0.
  - oData <= InvSubBytes(InvShiftRows(state_reg)) ^ iRoundKey.
  - Go to DONE.
- DONE:
  - oValid=1; oData is held stable while iReady=0.
  - On iReady=1: oValid deasserts next cycle and the FSM returns to IDLE.
  - No accept in the same cycle as the DONE handshake.
- Latency: handshake accept at cycle 0, oValid=1 at cycle 11. Throughput is one block per at least 12 cycles.
- Transforms:
  - InvShiftRows rotates row r right by r: out[r][c] = in[r][(c-r) mod 4].
  - InvSubBytes uses the FIPS-197 inverse S-box.
  - InvMixColumns uses matrix {0e,0b,0d,09} in GF(2^8) with polynomial 0x11B.
- Boundary rules:
  - iValid while not IDLE is ignored; nothing is buffered.
  - iData and iRoundKey are sampled only in the documented cycles.
  - Reset mid-operation aborts at once: the partial state is discarded and oValid=0.
  - oKeyIdx is always in the range 0..10.

Decomposition:
- Shared package aes_pkg holds:
  - Constants AES_NR=10, AES_BLK_W=128.
  - Function gf_xtime.
  - Functions inv_shift_rows and inv_mix_columns (pure functions).
  - The byte-index mapping helper (row, col) -> bit offset 127-8*(4c+r).
- Sub-module aes_inv_sbox: combinational 8-bit lookup, instantiated 16x for the state.
- The FSM, counter and registers live in the top module.

Test Plan:
- FIPS-197 C.1: key 000102..0f (expanded round keys served by the bench), ct 69c4e0d86a7b0430d8cdb78070b4c55a -> oData 00112233445566778899aabbccddeeff, oValid at cycle 11. Check the oKeyIdx sequence 10,9,...,1,0.
- All-zero key, ct 66e94bd4ef8a2c3b884cfa59ca342b2e -> oData 0. Hold iReady=0 for 5 cycles: oValid and oData stay stable; oReady stays 0.
- Back-to-back blocks with iValid held high and iReady=1: the second block is accepted only when oReady=1 again (12 cycles after the first accept). Both results are correct.
- Pulse iValid during ROUND with different data -> ignored; the first result is unchanged.
- Assert iRst_n=0 at round 5 -> oValid=0, oReady=1, oData=0 immediately. Resending the C.1 vector afterwards gives the correct plaintext.
- Random encrypt/decrypt round-trip, 1000 blocks against a reference model -> no mismatches.
